nios_mem_arbiter: RTL and testbench

Two-master Avalon-MM arbiter that shares the Nios on-chip single-port RAM (14-bit word address, 32-bit data, byte enables, one-cycle read latency) between the CPU data master (m0) and a DMA/accelerator master (m1). It grants at most one access per cycle with round-robin fairness and drives the RAM's slave port directly. It tags each issued read so returning data is routed to the issuing master with `readdatavalid`, which allows back-to-back pipelined reads.

---
 rtl/nios_mem_arb_pkg.sv | 27 ++
 rtl/nios_mem_arb_rr.sv | 40 ++++
 rtl/nios_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_nios_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mem_arb_pkg.sv
// Shared types and constants for the two-master Nios on-chip RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a. RD_LAT follows NIOS_MEM_ARB_RDREG_EN (registered read return).
package nios_mem_arb_pkg;

  localparam int ARB_ADDR_W = 14;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  // Master index: 0 = CPU data master, 1 = DMA/accelerator master.
  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

`ifdef NIOS_MEM_ARB_RDREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  // One-hot grant vector for a master index.
  function automatic logic [1:0] idx2onehot(input mst_idx_t idx);
    return (idx == MST1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/nios_mem_arb_rr.sv
// Two-requester round-robin grant with a registered last-grant pointer.
// Latency: grant is combinational from req (0 cycles); pointer updates on the granting edge.
// Backpressure: a losing requester simply sees no grant and must hold its request.
module nios_mem_arb_rr import nios_mem_arb_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output mst_idx_t   gnt_idx
);

  mst_idx_t last_grant_q;
  mst_idx_t last_grant_d;

  // Pick the sole requester, or on contention the master that did not win last time.
  always_comb begin
    gnt_idx      = MST0;
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (req == 2'b11) begin
      gnt_idx = (last_grant_q == MST0) ? MST1 : MST0;
    end else if (req[1]) begin
      gnt_idx = MST1;
    end
    if (|req) begin
      gnt          = idx2onehot(gnt_idx);
      last_grant_d = gnt_idx;
    end
  end

  // Pointer resets to m1 so that m0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= MST1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/nios_mem_arbiter.sv
// Shares the single-port Nios RAM between m0 (CPU) and m1 (DMA), round-robin, one access per cycle.
// Latency: grant 0 cycles; read data 1 cycle after acceptance, 2 with NIOS_MEM_ARB_RDREG_EN.
// Backpressure: waitrequest high until granted; reads are tagged so returns pipeline back-to-back.
module nios_mem_arbiter import nios_mem_arb_pkg::*; #(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  mst_idx_t          gnt_idx;
  logic              any_gnt;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_pend_q, rd_pend_d;
  mst_idx_t          rd_tag_q, rd_tag_d;

  // No master can win while reset is held.
  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{~reset}};

  nios_mem_arb_rr u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Mux the granted master onto the RAM port and tag any read it issues.
  always_comb begin
    any_gnt        = |gnt;
    sel_wr         = (gnt_idx == MST1) ? m1_write      : m0_write;
    sel_addr       = (gnt_idx == MST1) ? m1_address    : m0_address;
    sel_be         = (gnt_idx == MST1) ? m1_byteenable : m0_byteenable;
    m0_waitrequest = ~gnt[0];
    m1_waitrequest = ~gnt[1];
    mem_chipselect = any_gnt;
    mem_write      = any_gnt & sel_wr;
    mem_address    = any_gnt ? sel_addr : addr_q;
    mem_byteenable = (any_gnt & sel_wr) ? sel_be : '1;
    mem_writedata  = (gnt_idx == MST1) ? m1_writedata : m0_writedata;
    mem_clken      = ~reset;
    addr_d         = mem_address;
    // read+write together is serviced as a write, so it never returns data
    rd_pend_d      = any_gnt & ~sel_wr;
    rd_tag_d       = (any_gnt & ~sel_wr) ? gnt_idx : rd_tag_q;
  end

  // Address hold register and the one-deep read tag stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= MST0;
    end else begin
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

`ifdef NIOS_MEM_ARB_RDREG_EN
  logic [1:0]        rvld_q, rvld_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Steer the RAM output into the tagged master's return register.
  always_comb begin
    rvld_d[0] = rd_pend_q & (rd_tag_q == MST0);
    rvld_d[1] = rd_pend_q & (rd_tag_q == MST1);
    rdata0_d  = rvld_d[0] ? mem_readdata : rdata0_q;
    rdata1_d  = rvld_d[1] ? mem_readdata : rdata1_q;
  end

  // Registered return: no combinational path from mem_readdata to the masters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvld_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvld_q   <= rvld_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_readdatavalid = rvld_q[0];
  assign m1_readdatavalid = rvld_q[1];
  assign m0_readdata      = rdata0_q;
  assign m1_readdata      = rdata1_q;
`else
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Pass the RAM output straight to the tagged master; the other keeps its last data.
  always_comb begin
    m0_readdatavalid = rd_pend_q & ~reset & (rd_tag_q == MST0);
    m1_readdatavalid = rd_pend_q & ~reset & (rd_tag_q == MST1);
    m0_readdata      = m0_readdatavalid ? mem_readdata : rdata0_q;
    m1_readdata      = m1_readdatavalid ? mem_readdata : rdata1_q;
    rdata0_d         = m0_readdata;
    rdata1_d         = m1_readdata;
  end

  // Hold registers so readdata stays stable between returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
`endif

  // Flag a master driving read and write together; the access is serviced as a write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_m0_rw: assert (!(m0_read && m0_write))
        else $warning("m0 asserted read and write together; handled as a write");
      a_m1_rw: assert (!(m1_read && m1_write))
        else $warning("m1 asserted read and write together; handled as a write");
    end
  end

endmodule

// File: tb/tb_nios_mem_arbiter.sv
module tb_nios_mem_arbiter;
  import nios_mem_arb_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m1_read, m0_write, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc_cnt = 0;
  int            vcnt0 = 0;
  int            vcnt1 = 0;
  logic          lg = 1'b1;

  nios_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered q, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_q;

  // Return monitor: every valid must match the head of that master's scoreboard on its due cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc_cnt = cyc_cnt + 1;
    #2;
    if (m0_readdatavalid === 1'b1) begin
      vcnt0++;
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL m0_unexpected_valid cycle %0d: got valid with data %h, required no valid", cyc_cnt, m0_readdata);
      end else begin
        e = q0.pop_front();
        if (m0_readdata !== e.data || cyc_cnt != e.due) begin
          miscompares++;
          $display("FAIL m0_return: got data %h at cycle %0d, required %h at cycle %0d", m0_readdata, cyc_cnt, e.data, e.due);
        end
      end
    end else if (q0.size() > 0) begin
      if (q0[0].due <= cyc_cnt) begin
        vectors++;
        miscompares++;
        $display("FAIL m0_missing_valid: got no valid at cycle %0d, required data %h", cyc_cnt, q0[0].data);
        void'(q0.pop_front());
      end
    end
    if (m1_readdatavalid === 1'b1) begin
      vcnt1++;
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL m1_unexpected_valid cycle %0d: got valid with data %h, required no valid", cyc_cnt, m1_readdata);
      end else begin
        e = q1.pop_front();
        if (m1_readdata !== e.data || cyc_cnt != e.due) begin
          miscompares++;
          $display("FAIL m1_return: got data %h at cycle %0d, required %h at cycle %0d", m1_readdata, cyc_cnt, e.data, e.due);
        end
      end
    end else if (q1.size() > 0) begin
      if (q1[0].due <= cyc_cnt) begin
        vectors++;
        miscompares++;
        $display("FAIL m1_missing_valid: got no valid at cycle %0d, required data %h", cyc_cnt, q1[0].data);
        void'(q1.pop_front());
      end
    end
  end

  // Apply an accepted access to the reference memory and queue the expected read return.
  task automatic accept(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
    exp_t e;
    if (wr) begin
      for (int b = 0; b < BW; b++)
        if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
    end else if (rd) begin
      e.data = shadow[a];
      e.due  = cyc_cnt + RD_LAT;
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // One clock: sample waitrequest just before the edge, predict the grant, advance past the edge.
  task automatic step(output logic w0, output logic w1, output logic e0, output logic e1);
    logic r0, r1;
    int   g;
    @(negedge clk);
    #4;
    w0 = m0_waitrequest;
    w1 = m1_waitrequest;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g  = -1;
    if (reset)         lg = 1'b1;
    else if (r0 && r1) g = lg ? 0 : 1;
    else if (r0)       g = 0;
    else if (r1)       g = 1;
    e0 = (g != 0);
    e1 = (g != 1);
    if (g == 0) begin
      lg = 1'b0;
      accept(0, m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
    end else if (g == 1) begin
      lg = 1'b1;
      accept(1, m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic w0, w1, e0, e1;
    reset = 1'b1;
    m0_read = 1'b1; m1_read = 1'b1;
    m0_address = 14'h5; m1_address = 14'h6;
    for (int k = 0; k < 2; k++) begin
      step(w0, w1, e0, e1);
      vectors++;
      if (w0 !== 1'b1 || w1 !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_waitrequest: got %b%b, required 11", w0, w1);
      end
    end
    #1;
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid, mem_chipselect, mem_write, mem_clken} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got vld0/vld1/cs/wr/clken %b%b%b%b%b, required 00000",
               m0_readdatavalid, m1_readdatavalid, mem_chipselect, mem_write, mem_clken);
    end
    vectors++;
    if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_readdata: got %h %h, required 0 0", m0_readdata, m1_readdata);
    end
    reset = 1'b0;
    m0_read = 1'b0; m1_read = 1'b0;
    step(w0, w1, e0, e1);
    vectors++;
    if (w0 !== 1'b1 || w1 !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_waitrequest: got %b%b, required 11", w0, w1);
    end
  endtask

  task automatic test_single_read();
    logic w0, w1, e0, e1;
    int   v1;
    v1 = vcnt1;
    m0_read = 1'b1; m0_address = 14'h0010;
    step(w0, w1, e0, e1);
    vectors++;
    if (w0 !== 1'b0 || w1 !== 1'b1) begin
      miscompares++;
      $display("FAIL single_read_grant: got wait %b%b, required 01", w0, w1);
    end
    m0_read = 1'b0;
    vectors++;
    if (mem_clken !== 1'b1) begin
      miscompares++;
      $display("FAIL clken_run: got %b, required 1", mem_clken);
    end
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
    vectors++;
    if (m0_readdata !== 32'hDEADBEEF || vcnt1 != v1) begin
      miscompares++;
      $display("FAIL single_read_data: got %h (m1 valids %0d), required deadbeef (0)", m0_readdata, vcnt1 - v1);
    end
  endtask

  task automatic test_contention();
    logic          w0, w1, e0, e1;
    logic [AW-1:0] a0, a1;
    int            v0, v1;
    v0 = vcnt0; v1 = vcnt1;
    a0 = 14'h20; a1 = 14'h60;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m0_address = a0; m1_address = a1;
      step(w0, w1, e0, e1);
      vectors++;
      if (w0 !== e0 || w1 !== e1) begin
        miscompares++;
        $display("FAIL contention_grant[%0d]: got wait %b%b, required %b%b", k, w0, w1, e0, e1);
      end
      if (!e0) a0 = a0 + 14'h1;
      if (!e1) a1 = a1 + 14'h1;
    end
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
    vectors++;
    if (vcnt0 - v0 != 4 || vcnt1 - v1 != 4) begin
      miscompares++;
      $display("FAIL contention_share: got %0d/%0d returns, required 4/4", vcnt0 - v0, vcnt1 - v1);
    end
  endtask

  task automatic test_byte_write();
    logic w0, w1, e0, e1;
    m1_write = 1'b1; m1_address = 14'h0100; m1_writedata = 32'h000000AA; m1_byteenable = 4'b0001;
    step(w0, w1, e0, e1);
    vectors++;
    if (w0 !== 1'b1 || w1 !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_write_grant: got wait %b%b, required 10", w0, w1);
    end
    m1_write = 1'b0;
    m0_read = 1'b1; m0_address = 14'h0100;
    step(w0, w1, e0, e1);
    m0_read = 1'b0;
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
    vectors++;
    if (m0_readdata !== 32'h112233AA) begin
      miscompares++;
      $display("FAIL byte_write_merge: got %h, required 112233aa", m0_readdata);
    end
  endtask

  task automatic test_back_to_back();
    logic w0, w1, e0, e1;
    int   v0;
    v0 = vcnt0;
    for (int k = 1; k <= 8; k++) begin
      m0_read = 1'b1; m0_address = AW'(k);
      step(w0, w1, e0, e1);
      vectors++;
      if (w0 !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_grant[%0d]: got wait %b, required 0", k, w0);
      end
    end
    m0_read = 1'b0;
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
    vectors++;
    if (vcnt0 - v0 != 8) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d returns, required 8", vcnt0 - v0);
    end
  endtask

  task automatic test_rw_both();
    logic w0, w1, e0, e1;
    int   v0;
    v0 = vcnt0;
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 14'h0030;
    m0_writedata = 32'h55667788; m0_byteenable = 4'hF;
    step(w0, w1, e0, e1);
    vectors++;
    if (w0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_grant: got wait %b, required 0", w0);
    end
    m0_read = 1'b0; m0_write = 1'b0;
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
    vectors++;
    if (vcnt0 != v0) begin
      miscompares++;
      $display("FAIL rw_no_return: got %0d returns, required 0", vcnt0 - v0);
    end
    m0_read = 1'b1;
    step(w0, w1, e0, e1);
    m0_read = 1'b0;
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
    vectors++;
    if (m0_readdata !== 32'h55667788) begin
      miscompares++;
      $display("FAIL rw_as_write: got %h, required 55667788", m0_readdata);
    end
  endtask

  task automatic test_reset_mid_read();
    logic w0, w1, e0, e1;
    int   v1;
    m1_read = 1'b1; m1_address = 14'h0040;
    step(w0, w1, e0, e1);
    vectors++;
    if (w1 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_read_grant: got wait %b, required 0", w1);
    end
    reset = 1'b1;
    m1_read = 1'b0;
    q1.delete();
    v1 = vcnt1;
    step(w0, w1, e0, e1);
    reset = 1'b0;
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
    vectors++;
    if (vcnt1 != v1 || m1_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_read_drop: got %0d returns data %h, required 0 returns data 0", vcnt1 - v1, m1_readdata);
    end
    m0_read = 1'b1; m1_read = 1'b1; m0_address = 14'h41; m1_address = 14'h42;
    step(w0, w1, e0, e1);
    vectors++;
    if (w0 !== 1'b0 || w1 !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_contention: got wait %b%b, required 01", w0, w1);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (RD_LAT + 1) step(w0, w1, e0, e1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = 32'h5A000000 | i;
      shadow[i] = 32'h5A000000 | i;
    end
    ram[16'h0010] = 32'hDEADBEEF; shadow[16'h0010] = 32'hDEADBEEF;
    ram[16'h0100] = 32'h11223344; shadow[16'h0100] = 32'h11223344;
    m0_address = '0; m1_address = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_read = 1'b0; m1_read = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
    m0_writedata = '0; m1_writedata = '0;

    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_back_to_back();
    test_rw_both();
    test_reset_mid_read();

    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d outstanding reads, required 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
